// File: rtl/avalon_pkg.sv
// Shared types and widths for the Avalon slave datapath.
// Burst FSM encoding and address/data widths.
package avalon_pkg;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;
  localparam int BCNT_W = 10;
  localparam logic [ADDR_W-1:0] MAXADDR = 11'h62C;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    BDONE
  } burst_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO whose head sits in a register,
// with first-word fall-through into that register.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     valid,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_n;
  logic [CW-1:0]    cnt_n;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  always_comb begin
    do_pop  = pop & valid;
    do_push = push & (~full | do_pop);
    rd_n    = rd_ptr + AW'(do_pop);
    cnt_n   = count + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Head register picks up the next entry, bypassing
  // the array when that entry is being written now.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
      dout   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_n;
      count  <= cnt_n;
      valid  <= (cnt_n != '0);
      if (cnt_n != '0) begin
        if (do_push && (wr_ptr == rd_n)) dout <= din;
        else                             dout <= mem[rd_n];
      end
    end
  end

endmodule

// File: rtl/avalon_write_buffer.sv
// Write buffer between the Avalon slave controller and SRAM:
// burst address generation, beat FIFO and drain handshake.
module avalon_write_buffer
  import avalon_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = ADDR_W,
  parameter int DW    = DATA_W,
  parameter int BW    = BCNT_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          burst_start,
  input  logic [AW-1:0] burst_base,
  input  logic [BW-1:0] burst_len,
  input  logic          w_ena,
  input  logic          count_ena,
  input  logic [AW-1:0] address,
  input  logic [DW-1:0] writedata,
  output logic          done_burst,
  output logic          full,
  output logic          overflow_err,
  output logic          mem_wr_valid,
  input  logic          mem_wr_ready,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata
);

  localparam int CW = $clog2(DEPTH) + 1;

  burst_state_t    state;
  logic [AW-1:0]   base;
  logic [BW-1:0]   len;
  logic [BW-1:0]   beat_cnt;
  logic            in_burst;
  logic            push_req;
  logic            pop;
  logic            accept;
  logic            last_beat;
  logic [AW-1:0]   push_addr;
  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;

  always_comb begin
    in_burst  = (state == BURST);
    push_req  = in_burst ? count_ena : w_ena;
    push_addr = in_burst ? AW'(base + AW'(beat_cnt)) : address;
    full      = (fifo_count == CW'(DEPTH));
    pop       = mem_wr_ready & ~fifo_empty;
    accept    = push_req & (~full | pop);
    last_beat = (beat_cnt + BW'(1)) == len;
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (AW + DW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (pop),
    .din   ({push_addr, writedata}),
    .dout  ({mem_addr, mem_wdata}),
    .valid (mem_wr_valid),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      base         <= '0;
      len          <= '0;
      beat_cnt     <= '0;
      done_burst   <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      if (push_req && !accept) overflow_err <= 1'b1;
      if (burst_start) begin
        state      <= BURST;
        base       <= burst_base;
        len        <= (burst_len == '0) ? BW'(1) : burst_len;
        beat_cnt   <= '0;
        done_burst <= 1'b0;
      end else begin
        unique case (1'b1)
          state == BURST: begin
            if (accept) begin
              beat_cnt <= beat_cnt + BW'(1);
              if (last_beat) begin
                state      <= BDONE;
                done_burst <= 1'b1;
              end
            end
          end
          state == BDONE: begin
            if (!w_ena && !count_ena) begin
              state      <= IDLE;
              done_burst <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_avalon_write_buffer.sv
// Randomized bench for avalon_write_buffer against a
// queue-based model of the buffer contents.
module tb_avalon_write_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        burst_start;
  logic [10:0] burst_base;
  logic [9:0]  burst_len;
  logic        w_ena;
  logic        count_ena;
  logic [10:0] address;
  logic [31:0] writedata;
  logic        done_burst;
  logic        full;
  logic        overflow_err;
  logic        mem_wr_valid;
  logic        mem_wr_ready;
  logic [10:0] mem_addr;
  logic [31:0] mem_wdata;

  always #5 clk = ~clk;

  avalon_write_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .burst_start  (burst_start),
    .burst_base   (burst_base),
    .burst_len    (burst_len),
    .w_ena        (w_ena),
    .count_ena    (count_ena),
    .address      (address),
    .writedata    (writedata),
    .done_burst   (done_burst),
    .full         (full),
    .overflow_err (overflow_err),
    .mem_wr_valid (mem_wr_valid),
    .mem_wr_ready (mem_wr_ready),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata)
  );

  int n_chk = 0;
  int n_bad = 0;

  logic [42:0] q[$];
  bit          m_burst;
  bit          m_done;
  bit          m_ovf;
  logic [10:0] m_base;
  int          m_len;
  int          m_n;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h t=%0t",
               tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    bit          pop;
    bit          preq;
    bit          acc;
    logic [10:0] a;
    logic [42:0] e;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_burst = 0;
      m_done  = 0;
      m_ovf   = 0;
      m_n     = 0;
    end else begin
      pop  = (q.size() != 0) && mem_wr_ready;
      preq = m_burst ? count_ena : w_ena;
      a    = m_burst ? m_base + 11'(m_n) : address;
      acc  = preq && ((q.size() < 8) || pop);
      if (pop) void'(q.pop_front());
      if (acc) q.push_back({a, writedata});
      if (preq && !acc) m_ovf = 1;
      if (burst_start) begin
        m_burst = 1;
        m_done  = 0;
        m_base  = burst_base;
        m_len   = (burst_len == 0) ? 1 : int'(burst_len);
        m_n     = 0;
      end else if (m_burst && acc) begin
        m_n++;
        if (m_n == m_len) begin
          m_burst = 0;
          m_done  = 1;
        end
      end else if (m_done && !w_ena && !count_ena) begin
        m_done = 0;
      end
    end
    #1;
    chk("valid", 32'(mem_wr_valid), 32'(q.size() != 0));
    chk("full", 32'(full), 32'(q.size() == 8));
    chk("ovf", 32'(overflow_err), 32'(m_ovf));
    chk("done", 32'(done_burst), 32'(m_done));
    if (q.size() != 0) begin
      e = q[0];
      chk("addr", 32'(mem_addr), 32'(e[42:32]));
      chk("data", mem_wdata, e[31:0]);
    end else if (rst) begin
      chk("rst_addr", 32'(mem_addr), 32'h0);
      chk("rst_data", mem_wdata, 32'h0);
    end
  endtask

  task automatic quiet();
    burst_start = 0;
    w_ena       = 0;
    count_ena   = 0;
  endtask

  task automatic wr(input logic [10:0] a,
                    input logic [31:0] d);
    w_ena = 1; address = a; writedata = d;
    step();
    w_ena = 0;
  endtask

  task automatic burst(input logic [10:0] b,
                       input logic [9:0] l,
                       input int beats);
    burst_start = 1; burst_base = b; burst_len = l;
    step();
    burst_start = 0;
    for (int i = 0; i < beats; i++) begin
      count_ena = 1; writedata = $urandom;
      step();
    end
    count_ena = 0;
  endtask

  task automatic do_reset();
    quiet();
    rst = 1;
    step();
    rst = 0;
  endtask

  initial begin
    quiet();
    rst = 1; mem_wr_ready = 0;
    burst_base = 0; burst_len = 0;
    address = 0; writedata = 0;
    step();
    step();
    rst = 0;
    step();

    mem_wr_ready = 1;
    wr(11'h010, 32'hDEADBEEF);
    step();
    step();

    burst(11'h100, 10'd4, 4);
    chk("burst_done", 32'(done_burst), 32'h1);
    step();
    step();

    mem_wr_ready = 0;
    for (int i = 0; i < 9; i++)
      wr(11'(i + 1), $urandom);
    step();
    chk("ovf_sticky", 32'(overflow_err), 32'h1);
    chk("full8", 32'(full), 32'h1);
    mem_wr_ready = 1;
    for (int i = 0; i < 10; i++) step();

    do_reset();
    mem_wr_ready = 0;
    for (int i = 0; i < 8; i++)
      wr(11'(i + 32), $urandom);
    mem_wr_ready = 1;
    wr(11'h055, 32'h12345678);
    chk("fullpop_ovf", 32'(overflow_err), 32'h0);
    chk("fullpop_full", 32'(full), 32'h1);
    for (int i = 0; i < 10; i++) step();

    burst(11'h7FE, 10'd3, 3);
    step();
    burst(11'h200, 10'd0, 1);
    chk("len0_done", 32'(done_burst), 32'h1);
    step();
    step();

    mem_wr_ready = 0;
    burst(11'h300, 10'd4, 2);
    do_reset();
    chk("rst_valid", 32'(mem_wr_valid), 32'h0);
    step();
    mem_wr_ready = 1;
    wr(11'h0AA, 32'hCAFEF00D);
    step();

    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 299) == 0);
      burst_start  = ($urandom_range(0, 99) < 4);
      burst_base   = 11'($urandom);
      burst_len    = ($urandom_range(0, 9) == 0) ?
                     10'($urandom_range(0, 20)) :
                     10'($urandom_range(0, 5));
      w_ena        = ($urandom_range(0, 99) < 30);
      count_ena    = ($urandom_range(0, 99) < 50);
      address      = 11'($urandom);
      writedata    = $urandom;
      mem_wr_ready = ($urandom_range(0, 99) < 60);
      step();
    end
    rst = 0;
    quiet();
    mem_wr_ready = 1;
    for (int i = 0; i < 12; i++) step();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
